// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Hazard and flush sequencer for a 5-stage fetch/decode/execute/memory/
// writeback pipeline. A 3-entry scoreboard records the destination register
// of each instruction currently in EX, MEM and WB. A decode-stage reader of
// a register that one of those entries still has to write gets stalled. A
// taken branch or jump resolved in EX flushes the front end. Saturating
// counters record the number of stalled cycles and taken redirects.
//
// Parameters:
//   REG_AW     register address width (x0 never hazards)
//   CNT_W      width of the stall / flush statistic counters
//   WB_HAZARD  1 = WB entry still blocks readers, 0 = register bank is
//              write-through and the WB entry is ignored
//
// Ports:
//   clk_i           pipeline clock, rising edge
//   reset_i         asynchronous active-high reset, clears all state
//   dec_valid_i     decode stage holds a real instruction
//   dec_rs1_i       decode source register 1
//   dec_rs2_i       decode source register 2
//   dec_use_rs1_i   instruction reads rs1
//   dec_use_rs2_i   instruction reads rs2
//   dec_rd_i        decode destination register
//   dec_regwrite_i  decode instruction writes rd
//   ex_redirect_i   branch taken / jump in execute
//   pc_en_o         pc register load enable
//   ifid_en_o       fetch-to-decode buffer load enable
//   ifid_flush_o    load a bubble into the fetch-to-decode buffer
//   idex_flush_o    load a bubble into the decode-to-execute buffers
//   stall_o         RAW hazard stall active this cycle
//   stall_count_o   cycles stalled, saturating
//   flush_count_o   redirects taken, saturating
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 16,
    parameter int WB_HAZARD = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              dec_valid_i,
    input  logic [REG_AW-1:0] dec_rs1_i,
    input  logic [REG_AW-1:0] dec_rs2_i,
    input  logic              dec_use_rs1_i,
    input  logic              dec_use_rs2_i,
    input  logic [REG_AW-1:0] dec_rd_i,
    input  logic              dec_regwrite_i,
    input  logic              ex_redirect_i,
    output logic              pc_en_o,
    output logic              ifid_en_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_count_o,
    output logic [CNT_W-1:0]  flush_count_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
    } sb_entry_t;

    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [REG_AW-1:0] REG_X0  = '0;

    sb_entry_t        ex_q, mem_q, wb_q;
    sb_entry_t        ex_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic rs1_hit, rs2_hit;
    logic hazard, stall, issue;

    // Compare each used, non-x0 source against every scoreboard entry that
    // will still write the register file. The WB entry only counts when the
    // register bank cannot forward a same-cycle write to its read ports.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        if (dec_use_rs1_i && (dec_rs1_i != REG_X0)) begin
            if (ex_q.valid && ex_q.wr && (ex_q.rd == dec_rs1_i))
                rs1_hit = 1'b1;
            if (mem_q.valid && mem_q.wr && (mem_q.rd == dec_rs1_i))
                rs1_hit = 1'b1;
            if ((WB_HAZARD != 0) && wb_q.valid && wb_q.wr && (wb_q.rd == dec_rs1_i))
                rs1_hit = 1'b1;
        end
        if (dec_use_rs2_i && (dec_rs2_i != REG_X0)) begin
            if (ex_q.valid && ex_q.wr && (ex_q.rd == dec_rs2_i))
                rs2_hit = 1'b1;
            if (mem_q.valid && mem_q.wr && (mem_q.rd == dec_rs2_i))
                rs2_hit = 1'b1;
            if ((WB_HAZARD != 0) && wb_q.valid && wb_q.wr && (wb_q.rd == dec_rs2_i))
                rs2_hit = 1'b1;
        end
    end

    // A redirect wins over a stall: the stalled instruction is on the wrong
    // path and is about to be replaced by a bubble anyway.
    always_comb begin
        hazard = dec_valid_i && (rs1_hit || rs2_hit);
        stall  = hazard && !ex_redirect_i;
        issue  = dec_valid_i && !stall && !ex_redirect_i;
    end

    assign stall_o      = stall;
    assign pc_en_o      = !stall;
    assign ifid_en_o    = !stall;
    assign ifid_flush_o = ex_redirect_i;
    assign idex_flush_o = stall || ex_redirect_i;

    // Next EX entry: the issuing instruction, or an all-zero bubble when
    // decode stalls, is flushed or is empty. Writes to x0 are never tracked.
    always_comb begin
        ex_d = '0;
        if (issue) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = dec_rd_i;
            ex_d.wr    = dec_regwrite_i && (dec_rd_i != REG_X0);
        end
    end

    // Saturating statistics: hold at all-ones rather than wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall && (stall_count_q != CNT_MAX))
            stall_count_d = stall_count_q + CNT_ONE;
        if (ex_redirect_i && (flush_count_q != CNT_MAX))
            flush_count_d = flush_count_q + CNT_ONE;
    end

    // Scoreboard shifts every cycle; the redirecting instruction in EX moves
    // on to MEM/WB untouched so a jump's link write stays tracked.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= ex_q;
            wb_q          <= mem_q;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count_o = stall_count_q;
    assign flush_count_o = flush_count_q;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage fetch/decode/execute/memory/writeback datapath.
- Tracks in-flight register writes in a 3-entry scoreboard covering EX, MEM and WB.
- Stalls fetch/decode on read-after-write hazards and flushes the front end on a taken branch or jump resolved in execute.
- Sits beside the pipeline buffers and drives their enables and flushes; it also keeps saturating stall and flush statistics.

Parameters:
- REG_AW, 5, register address width (32 architectural registers; x0 never hazards)
- CNT_W, 16, width of the stall and flush statistic counters
- WB_HAZARD, 1, 1 = an instruction in WB still blocks readers (register bank is not write-through); 0 = WB entry ignored for hazard checks

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- dec_valid  input  1  decode stage holds a real instruction
- dec_rs1  input  REG_AW  decode source register 1
- dec_rs2  input  REG_AW  decode source register 2
- dec_use_rs1  input  1  instruction reads rs1
- dec_use_rs2  input  1  instruction reads rs2
- dec_rd  input  REG_AW  decode destination register
- dec_regwrite  input  1  decode instruction writes rd
- ex_redirect  input  1  branch taken or jump in execute (pc mux selects target)
- pc_en  output  1  pc register load enable
- ifid_en  output  1  fetch-to-decode buffer load enable
- ifid_flush  output  1  load a bubble (NOP) into the fetch-to-decode buffer
- idex_flush  output  1  load a bubble into the decode-to-execute buffers
- stall  output  1  RAW hazard stall active this cycle
- stall_count  output  CNT_W  cycles stalled, saturating
- flush_count  output  CNT_W  redirects taken, saturating

Behaviour:
- Scoreboard: entries EX, MEM, WB, each {valid, rd, wr}; registered; reset clears all valid bits.
- Hazard (combinational): dec_valid and, for some used rsN, rsN != 0 and a scoreboard entry exists with valid and wr and rd == rsN. The WB entry participates only when WB_HAZARD = 1.
- stall = hazard and not ex_redirect. A redirect overrides a stall, because the stalled instruction is on the wrong path.
- pc_en = ifid_en = not stall.
- idex_flush = stall or ex_redirect.
- ifid_flush = ex_redirect.
- issue = dec_valid and not stall and not ex_redirect.
- Scoreboard update on each rising clk edge:
  - WB <= MEM; MEM <= EX.
  - EX <= {1, dec_rd, dec_regwrite and dec_rd != 0} when issue; otherwise EX <= all-zero (bubble).
- The redirecting instruction in EX continues to MEM/WB unchanged, so a jump's link write still tracks.
- Latency:
  - stall and flush outputs are same-cycle (combinational from registered scoreboard and inputs).
  - A RAW hazard on an immediately preceding producer stalls 3 cycles with WB_HAZARD = 1, or 2 cycles with WB_HAZARD = 0.
  - A producer two instructions ahead stalls 2 cycles (1 with WB_HAZARD = 0).
- Both rs1 and rs2 hazarding against different entries: the stall lasts until the youngest matching entry clears.
- stall_count increments on each clk edge where stall = 1.
- flush_count increments on each edge where ex_redirect = 1.
- Both counters hold at all-ones (saturate) and never wrap.
- Reset, asynchronous and valid mid-operation:
  - scoreboard cleared and counters zeroed immediately.
  - Outputs then follow from the cleared state: stall = 0, pc_en = ifid_en = 1, and flushes reflect only ex_redirect.
- Reset value of every output with inputs idle: pc_en = 1, ifid_en = 1, ifid_flush = 0, idex_flush = 0, stall = 0, counts = 0.
- dec_valid = 0: no hazard and no issue; a bubble enters EX.

Test Plan:
- Back-to-back dependency (add x5; then sub x6,x5,x1), WB_HAZARD = 1 -> stall = 1 for exactly 3 cycles, pc_en = 0 during them, idex_flush = 1 for 3 cycles; the sub issues on cycle 4; stall_count = 3.
- Same sequence with WB_HAZARD = 0 -> stall = 2 cycles; stall_count = 2.
- Producer writing x0 (addi x0) followed by a reader of x0 -> no stall; the EX entry has wr = 0.
- ex_redirect = 1 while decode holds a hazarding instruction -> stall = 0, ifid_flush = 1, idex_flush = 1, EX becomes a bubble next cycle; flush_count = 1.
- Independent stream of 10 instructions (no register overlap) -> stall never asserts, pc_en constantly 1, scoreboard valid bits follow the issue pattern.
- Force stall_count to all-ones (CNT_W = 4: 15 stalled cycles, then one more) -> holds at 15. Assert reset mid-stall -> stall drops and counters read 0 before the next clk edge.
